// File: rtl/dmem_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lsu_if
//  Description : Request/response bus between the core MEM stage and dmem_lsu.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_lsu_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lsu
//  Description : Word-array data memory with RV32I byte/half/word load/store
//                front end, optional wait states and access error reporting.
//                Define DMEM_CLEAR_ON_RESET_EN to zero the array after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    dmem_lsu_if.slave  bus
);

    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_IDLE = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [31:0]       r_wdata;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_busy;
    logic [31:0]       r_mem [DEPTH_WORDS];
`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [c_IDX_W-1:0] r_clr_idx;
`endif

    logic              w_in_idle;
    logic              w_accept;
    logic              w_commit;
    logic              w_op_we;
    logic [ADDR_W-1:0] w_op_addr;
    logic [2:0]        w_op_funct3;
    logic [31:0]       w_op_wdata;
    logic              w_size_bad;
    logic              w_misalign;
    logic              w_oor;
    logic              w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]       w_rd_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic [31:0]       w_rsp_rdata;
    logic [3:0]        w_be;
    logic [31:0]       w_wlane;
    logic              w_mem_we;

    assign w_in_idle = (r_state == c_ST_IDLE);
    assign w_accept  = w_in_idle && r_req_ready && bus.req_valid;

    // With no wait states the access commits on the accept edge, so the
    // live request is used until the latched copy becomes valid.
    assign w_op_we     = w_in_idle ? bus.req_we     : r_we;
    assign w_op_addr   = w_in_idle ? bus.req_addr   : r_addr;
    assign w_op_funct3 = w_in_idle ? bus.req_funct3 : r_funct3;
    assign w_op_wdata  = w_in_idle ? bus.req_wdata  : r_wdata;

    assign w_commit = !reset &&
                      ((w_accept && (WAIT_CYCLES == 0)) ||
                       ((r_state == c_ST_WAIT) && (r_cnt == 4'd0)));

    assign w_size_bad = w_op_we ? (w_op_funct3 > 3'b010)
                                : ((w_op_funct3 == 3'b011) || (w_op_funct3 == 3'b110) ||
                                   (w_op_funct3 == 3'b111));
    assign w_misalign = ((w_op_funct3[1:0] == 2'b01) && w_op_addr[0]) ||
                        ((w_op_funct3[1:0] == 2'b10) && (w_op_addr[1:0] != 2'b00));

    generate
        if (ADDR_W > c_IDX_W + 2) begin : g_range_chk
            assign w_oor = |w_op_addr[ADDR_W-1:c_IDX_W+2];
        end else begin : g_range_full
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_err     = w_size_bad || w_misalign || w_oor;
    assign w_idx     = w_op_addr[c_IDX_W+1:2];
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_byte = 8'h00;
        case (w_op_addr[1:0])
            2'd0: w_byte = w_rd_word[7:0];
            2'd1: w_byte = w_rd_word[15:8];
            2'd2: w_byte = w_rd_word[23:16];
            2'd3: w_byte = w_rd_word[31:24];
        endcase
        w_half      = w_op_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        w_load_data = 32'h0;
        case (w_op_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_rd_word;
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = 32'h0;
        endcase
    end

    assign w_rsp_rdata = (w_op_we || w_err) ? 32'h0 : w_load_data;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b1111;
        w_wlane = w_op_wdata;
        case (w_op_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_op_addr[1:0];
                w_wlane = {4{w_op_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_op_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_mem_we = w_commit && w_op_we && !w_err;

    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (!reset && (r_state == c_ST_INIT)) begin
            r_mem[r_clr_idx] <= 32'h0;
        end else
`endif
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
            r_state   <= c_ST_INIT;
            r_clr_idx <= '0;
`else
            r_state   <= c_ST_IDLE;
`endif
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_funct3    <= 3'b000;
            r_wdata     <= 32'h0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                c_ST_INIT: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
                    if (r_clr_idx == c_IDX_W'(DEPTH_WORDS - 1)) begin
                        r_state     <= c_ST_IDLE;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
`else
                    r_state <= c_ST_IDLE;
`endif
                end
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.req_we;
                        r_addr      <= bus.req_addr;
                        r_funct3    <= bus.req_funct3;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= c_ST_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end else begin
                            r_state     <= c_ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_rdata <= w_rsp_rdata;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= c_ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= w_rsp_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    r_state     <= c_ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_lsu
//  Description : Self-checking bench: two dmem_lsu instances (3 and 0 wait
//                states) checked against a byte-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

    localparam int DEPTH  = 16;
    localparam int AW     = 32;
    localparam int WAIT_A = 3;
    localparam int WAIT_B = 0;
`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam int BUSY_AFTER_RST = DEPTH;
`else
    localparam int BUSY_AFTER_RST = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(AW)) bus_a ();
    dmem_lsu_if #(.ADDR_W(AW)) bus_b ();

    dmem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    dmem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(WAIT_B)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model [0:1][0:DEPTH*4-1];

    function automatic int wait_of(input int d);
        return (d == 0) ? WAIT_A : WAIT_B;
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? bus_a.req_ready : bus_b.req_ready;
    endfunction
    function automatic logic get_rsp_valid(input int d);
        return (d == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
    endfunction
    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? bus_a.rsp_err : bus_b.rsp_err;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    task automatic drive(input int d, input logic v, input logic we, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd);
        if (d == 0) begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr;
            bus_a.req_funct3 = f3; bus_a.req_wdata = wd;
        end else begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr;
            bus_b.req_funct3 = f3; bus_b.req_wdata = wd;
        end
    endtask

    // Reference: little-endian byte array, RV32I size/sign rules.
    function automatic void model_op(input int d, input logic we, input logic [31:0] addr,
                                     input logic [2:0] f3, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic err);
        int size;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err  = 1'b0;
        rd   = 32'h0;
        if (we && f3 > 3'd2) err = 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) err = 1'b1;
        if (addr % size != 0) err = 1'b1;
        if ((addr >> 2) >= DEPTH) err = 1'b1;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) model[d][addr + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(model[d][addr + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8 * size));
            rd = v;
        end
    endfunction

    task automatic access(input int d, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err,
                          output int lat, output logic pulse_ok);
        logic r;
        bit   acc;
        acc = 0; lat = -1; rd = 'x; err = 'x; pulse_ok = 1'b0;
        @(negedge clk);
        drive(d, 1'b1, we, addr, f3, wd);
        for (int i = 0; i < 60 && !acc; i++) begin
            if (i > 0) @(negedge clk);
            r = get_ready(d);
            @(posedge clk);
            acc = (r === 1'b1);
        end
        #1 drive(d, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        if (!acc) return;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (get_rsp_valid(d) === 1'b1) begin
                lat = k; rd = get_rdata(d); err = get_err(d);
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            pulse_ok = (get_rsp_valid(d) === 1'b0);
        end
    endtask

    task automatic do_reset(output int bcnt_a, output int bcnt_b,
                            output bit rdy_bad, output bit rsp_seen);
        rsp_seen = 0; rdy_bad = 0; bcnt_a = 0; bcnt_b = 0;
        @(negedge clk);
        if (get_rsp_valid(0) === 1'b1 || get_rsp_valid(1) === 1'b1) rsp_seen = 1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        repeat (2) begin
            @(negedge clk);
            if (get_rsp_valid(0) === 1'b1 || get_rsp_valid(1) === 1'b1) rsp_seen = 1;
        end
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            if (get_rsp_valid(0) === 1'b1 || get_rsp_valid(1) === 1'b1) rsp_seen = 1;
            if (k > 0 && get_busy(0) === 1'b0 && get_busy(1) === 1'b0) break;
            if (get_busy(0) === 1'b1) bcnt_a++;
            if (get_busy(1) === 1'b1) bcnt_b++;
            if (get_ready(0) !== 1'b0 || get_ready(1) !== 1'b0) rdy_bad = 1;
            if (k == 0) reset = 1'b0;
        end
`ifdef DMEM_CLEAR_ON_RESET_EN
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH * 4; i++) model[d][i] = 8'h00;
`endif
    endtask

    task automatic test_reset();
        int  ba, bb;
        bit  rb, rs;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({get_ready(d), get_rsp_valid(d), get_err(d), get_busy(d)} !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset_ctrl dut%0d: {ready,rsp_valid,err,busy}=%b expected 0001", d,
                         {get_ready(d), get_rsp_valid(d), get_err(d), get_busy(d)});
            end
            n_tests++;
            if (get_rdata(d) !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata dut%0d: got %h expected 00000000", d, get_rdata(d));
            end
        end
        do_reset(ba, bb, rb, rs);
        n_tests++;
        if (ba != BUSY_AFTER_RST || bb != BUSY_AFTER_RST) begin
            n_fail++;
            $display("FAIL reset_busy_len: got %0d/%0d expected %0d", ba, bb, BUSY_AFTER_RST);
        end
        n_tests++;
        if (rb || rs) begin
            n_fail++;
            $display("FAIL reset_ready_or_rsp: ready_while_busy=%0d rsp_seen=%0d expected 0/0", rb, rs);
        end
    endtask

    task automatic test_fill();
        logic [31:0] rd, erd, wd;
        logic err, eerr, pok;
        int lat;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                wd = $urandom;
                model_op(d, 1'b1, 32'(w * 4), 3'b010, wd, erd, eerr);
                access(d, 1'b1, 32'(w * 4), 3'b010, wd, rd, err, lat, pok);
                n_tests++;
                if (err !== 1'b0 || rd !== 32'h0 || lat != wait_of(d) + 1 || pok !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fill dut%0d w%0d: err=%b rdata=%h lat=%0d pulse=%b expected 0/0/%0d/1",
                             d, w, err, rd, lat, pok, wait_of(d) + 1);
                end
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic test_directed();
        vec_t tbl [16];
        logic [31:0] rd, mrd;
        logic err, merr, pok;
        int lat;
        tbl[0]  = '{1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h13, 3'b000, 32'h00000080, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[4]  = '{1'b0, 32'h13, 3'b100, 32'h0,        32'h00000080, 1'b0};
        tbl[5]  = '{1'b0, 32'h10, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 32'h11, 3'b001, 32'h0000FFFF, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 32'h10, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0};
        tbl[8]  = '{1'b0, 32'h12, 3'b001, 32'h0,        32'hFFFF80AD, 1'b0};
        tbl[9]  = '{1'b0, 32'h12, 3'b101, 32'h0,        32'h000080AD, 1'b0};
        tbl[10] = '{1'b0, 32'(DEPTH * 4), 3'b010, 32'h0, 32'h0,       1'b1};
        tbl[11] = '{1'b0, 32'h10, 3'b011, 32'h0,        32'h0,        1'b1};
        tbl[12] = '{1'b1, 32'h10, 3'b011, 32'h0,        32'h0,        1'b1};
        tbl[13] = '{1'b1, 32'(DEPTH * 4), 3'b000, 32'h55, 32'h0,      1'b1};
        tbl[14] = '{1'b0, 32'h12, 3'b010, 32'h0,        32'h0,        1'b1};
        tbl[15] = '{1'b0, 32'h10, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0};
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                model_op(d, tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, mrd, merr);
                access(d, tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, rd, err, lat, pok);
                n_tests++;
                if (rd !== tbl[i].exp_rd || err !== tbl[i].exp_err) begin
                    n_fail++;
                    $display("FAIL directed dut%0d #%0d: rdata=%h err=%b expected %h/%b",
                             d, i, rd, err, tbl[i].exp_rd, tbl[i].exp_err);
                end
                n_tests++;
                if (lat != wait_of(d) + 1 || pok !== 1'b1) begin
                    n_fail++;
                    $display("FAIL directed_timing dut%0d #%0d: latency=%0d pulse=%b expected %0d/1",
                             d, i, lat, pok, wait_of(d) + 1);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wd;
        logic [2:0]  f3;
        logic we, err, eerr, pok;
        int lat, sel;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                sel  = $urandom_range(0, 9);
                addr = (sel == 0) ? 32'($urandom) :
                       (sel == 1) ? 32'(DEPTH * 4 + $urandom_range(0, 7)) :
                                    32'($urandom_range(0, DEPTH * 4 - 1));
                f3   = 3'($urandom_range(0, 7));
                we   = 1'($urandom_range(0, 1));
                wd   = $urandom;
                model_op(d, we, addr, f3, wd, erd, eerr);
                access(d, we, addr, f3, wd, rd, err, lat, pok);
                n_tests++;
                if (rd !== erd || err !== eerr || lat != wait_of(d) + 1 || pok !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random dut%0d we=%0d a=%h f3=%0d: rdata=%h err=%b lat=%0d pulse=%b expected %h/%b/%0d/1",
                             d, we, addr, f3, rd, err, lat, pok, erd, eerr, wait_of(d) + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        b_we [3];
        logic [31:0] b_addr [3];
        logic [2:0]  b_f3 [3];
        logic [31:0] b_wd [3];
        logic [31:0] exp_rd [3];
        logic        dummy;
        int          acc_cyc [3];
        int          rsp_cyc [$];
        logic [31:0] rsp_rd [$];
        logic        r;
        int          idx, w, base;
        for (int d = 0; d < 2; d++) begin
            w = wait_of(d);
            base = 4 * $urandom_range(0, DEPTH - 1);
            b_we[0] = 1'b1; b_addr[0] = 32'(base);     b_f3[0] = 3'b010; b_wd[0] = $urandom;
            b_we[1] = 1'b0; b_addr[1] = 32'(base + 2); b_f3[1] = 3'b001; b_wd[1] = 32'h0;
            b_we[2] = 1'b0; b_addr[2] = 32'(base);     b_f3[2] = 3'b010; b_wd[2] = 32'h0;
            for (int i = 0; i < 3; i++)
                model_op(d, b_we[i], b_addr[i], b_f3[i], b_wd[i], exp_rd[i], dummy);
            rsp_cyc.delete(); rsp_rd.delete();
            idx = 0;
            @(posedge clk);
            #1 drive(d, 1'b1, b_we[0], b_addr[0], b_f3[0], b_wd[0]);
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                r = get_ready(d);
                if (get_rsp_valid(d) === 1'b1) begin
                    rsp_cyc.push_back(c);
                    rsp_rd.push_back(get_rdata(d));
                end
                @(posedge clk);
                if (r === 1'b1 && idx < 3) begin
                    acc_cyc[idx] = c;
                    idx++;
                    #1;
                    if (idx < 3) drive(d, 1'b1, b_we[idx], b_addr[idx], b_f3[idx], b_wd[idx]);
                    else         drive(d, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
                end
            end
            n_tests++;
            if (idx != 3 || rsp_cyc.size() != 3) begin
                n_fail++;
                $display("FAIL b2b_count dut%0d: accepts=%0d responses=%0d expected 3/3", d, idx, rsp_cyc.size());
            end else begin
                for (int i = 1; i < 3; i++) begin
                    n_tests++;
                    if (acc_cyc[i] - acc_cyc[i-1] != w + 2) begin
                        n_fail++;
                        $display("FAIL b2b_period dut%0d #%0d: spacing=%0d expected %0d",
                                 d, i, acc_cyc[i] - acc_cyc[i-1], w + 2);
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    n_tests++;
                    if (rsp_cyc[i] != acc_cyc[i] + w + 1 || rsp_rd[i] !== exp_rd[i]) begin
                        n_fail++;
                        $display("FAIL b2b_rsp dut%0d #%0d: offset=%0d rdata=%h expected %0d/%h",
                                 d, i, rsp_cyc[i] - acc_cyc[i], rsp_rd[i], w + 1, exp_rd[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] addr, wd, rd, erd;
        logic err, eerr, pok, r;
        int lat, ba, bb;
        bit rb, rs;
        addr = 32'(4 * $urandom_range(0, DEPTH - 1));
        wd   = $urandom;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, addr, 3'b010, wd);
        r = get_ready(0);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        do_reset(ba, bb, rb, rs);
        n_tests++;
        if (r !== 1'b1 || rs) begin
            n_fail++;
            $display("FAIL reset_mid_drop: accepted=%b rsp_seen=%0d expected 1/0", r, rs);
        end
        n_tests++;
        if (ba != BUSY_AFTER_RST || rb) begin
            n_fail++;
            $display("FAIL reset_mid_busy: busy_len=%0d ready_while_busy=%0d expected %0d/0", ba, rb, BUSY_AFTER_RST);
        end
        model_op(0, 1'b0, addr, 3'b010, 32'h0, erd, eerr);
        access(0, 1'b0, addr, 3'b010, 32'h0, rd, err, lat, pok);
        n_tests++;
        if (rd !== erd || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_word a=%h: rdata=%h err=%b expected %h/0", addr, rd, err, erd);
        end
    endtask

    task automatic test_clear_seq();
        logic [31:0] rd, erd, exp;
        logic err, eerr, pok;
        int lat, ba, bb;
        bit rb, rs;
`ifdef DMEM_CLEAR_ON_RESET_EN
        exp = 32'h00000000;
`else
        exp = 32'h12345678;
`endif
        for (int d = 0; d < 2; d++) begin
            model_op(d, 1'b1, 32'h0, 3'b010, 32'h12345678, erd, eerr);
            access(d, 1'b1, 32'h0, 3'b010, 32'h12345678, rd, err, lat, pok);
        end
        do_reset(ba, bb, rb, rs);
        n_tests++;
        if (ba != BUSY_AFTER_RST || bb != BUSY_AFTER_RST || rb) begin
            n_fail++;
            $display("FAIL clear_busy: busy_len=%0d/%0d ready_while_busy=%0d expected %0d/0",
                     ba, bb, rb, BUSY_AFTER_RST);
        end
        for (int d = 0; d < 2; d++) begin
            access(d, 1'b0, 32'h0, 3'b010, 32'h0, rd, err, lat, pok);
            n_tests++;
            if (rd !== exp || err !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_word0 dut%0d: rdata=%h err=%b expected %h/0", d, rd, err, exp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_clear_seq();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
